// File: rtl/pes_lfsr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pes_lfsr_ctrl_pkg
// Shared definitions for the LFSR sequencer slice:
//   - LFSR geometry (width 4, feedback taps on bits 3 and 2)
//   - SAFE_SEED, which replaces an all-zero seed so the LFSR never locks up
//   - controller FSM state encoding (IDLE, LOAD, SHIFT, HOLD, DONE)
//   - fix_seed(): maps a requested seed to the seed that is actually loaded
// ---------------------------------------------------------------------------
package pes_lfsr_ctrl_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned TAP_HI = 3;
  localparam int unsigned TAP_LO = 2;

  localparam logic [LFSR_W-1:0] SAFE_SEED = 4'b0001;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // All-zero is the one lock-up state of an XOR-feedback LFSR.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SAFE_SEED : s;
  endfunction

endpackage

// File: rtl/pes_lfsr_core.sv
// ---------------------------------------------------------------------------
// pes_lfsr_core
// 4-bit Fibonacci LFSR, feedback q = s[3] ^ s[2], shifting left (q enters
// at bit 0). Period 15 for any non-zero state.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active-low; state returns to SAFE_SEED
//   en    in   advance one step this cycle
//   load  in   load seed this cycle (overrides en)
//   seed  in   value loaded when load=1
//   q     out  feedback bit of the current state (the next serial output)
// ---------------------------------------------------------------------------
module pes_lfsr_core
  import pes_lfsr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic              q
);

  logic [LFSR_W-1:0] r_s;

  assign q = r_s[TAP_HI] ^ r_s[TAP_LO];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s <= SAFE_SEED;
    end else if (load) begin
      r_s <= seed;
    end else if (en) begin
      r_s <= {r_s[LFSR_W-2:0], q};
    end
  end

endmodule

// File: rtl/pes_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// pes_lfsr_ctrl
// Job sequencer around pes_lfsr_core. A start request captures a seed and a
// word count; the LFSR is loaded, then clocked one bit per cycle into a
// WORD_W-bit shift register (first generated bit ends up in the MSB). Each
// full word is offered on a valid/ready handshake; the LFSR is frozen while
// a word waits, so the produced stream is independent of consumer stalls.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   start       in   job request, only honoured in IDLE
//   seed        in   LFSR seed, captured with start (0 is replaced by 0001)
//   num_words   in   number of words in the job, captured with start
//   abort       in   cancel the running job (no done pulse)
//   word        out  packed LFSR bits, MSB = first generated
//   word_valid  out  word holds a new value
//   word_ready  in   consumer accepts word
//   busy        out  a job is in progress
//   done        out  one-cycle pulse on normal completion
//   seed_fixed  out  the last captured seed was 0 and was replaced
// ---------------------------------------------------------------------------
module pes_lfsr_ctrl
  import pes_lfsr_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              abort,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              seed_fixed
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic              r_valid;
  logic              r_done;
  logic              r_seed_fixed;
  logic [LFSR_W-1:0] r_seed;
  logic [CNT_W-1:0]  r_words_left;
  logic [BIT_W-1:0]  r_bit;

  logic w_q;
  logic w_abort;
  logic w_load;
  logic w_en;

  // abort only acts outside IDLE; a start in the same IDLE cycle wins.
  assign w_abort = abort && (r_state != ST_IDLE);

  // The LFSR keeps its state across an abort, so an aborting cycle must
  // neither load nor step it.
  assign w_load = (r_state == ST_LOAD)  && !w_abort;
  assign w_en   = (r_state == ST_SHIFT) && !w_abort;

  pes_lfsr_core u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .load (w_load),
    .seed (r_seed),
    .q    (w_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_seed_fixed <= 1'b0;
      r_seed       <= '0;
      r_words_left <= '0;
      r_bit        <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_seed       <= fix_seed(seed);
              r_seed_fixed <= (seed == '0);
              r_words_left <= num_words;
              if (num_words == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            r_bit   <= '0;
            r_state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            r_word <= {r_word[WORD_W-2:0], w_q};
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
          ST_HOLD: begin
            if (word_ready) begin
              r_valid      <= 1'b0;
              r_words_left <= r_words_left - 1'b1;
              if (r_words_left == CNT_W'(1)) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_SHIFT;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign word       = r_word;
  assign word_valid = r_valid;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign seed_fixed = r_seed_fixed;

endmodule

// File: tb/tb_pes_lfsr_ctrl.sv
module tb_pes_lfsr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start15 = 1'b0;
  logic        abort = 1'b0;
  logic        word_ready = 1'b0;
  logic [3:0]  seed = 4'd0;
  logic [7:0]  num_words = 8'd0;

  logic [7:0]  word8;
  logic        valid8, busy8, done8, sf8;
  logic [14:0] word15;
  logic        valid15, busy15, done15, sf15;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pes_lfsr_ctrl #(.WORD_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_words(num_words),
    .abort(abort), .word(word8), .word_valid(valid8), .word_ready(word_ready),
    .busy(busy8), .done(done8), .seed_fixed(sf8)
  );

  pes_lfsr_ctrl #(.WORD_W(15), .CNT_W(8)) dut15 (
    .clk(clk), .rst(rst), .start(start15), .seed(seed), .num_words(num_words),
    .abort(abort), .word(word15), .word_valid(valid15), .word_ready(word_ready),
    .busy(busy15), .done(done15), .seed_fixed(sf15)
  );

  // Reference: the 15-state cycle of the LFSR starting from 0001. Any seed's
  // stream is this cycle read from that seed's position; output bit of a
  // state is bit3 xor bit2.
  int ref_state[15];

  function automatic logic [14:0] model_word(input logic [3:0] sd, input int w, input int idx);
    int eff;
    int off;
    int st;
    logic [14:0] r;
    eff = (sd == 4'd0) ? 1 : int'(sd);
    off = 0;
    for (int i = 0; i < 15; i++) if (ref_state[i] == eff) off = i;
    r = '0;
    for (int b = 0; b < w; b++) begin
      st = ref_state[(off + idx * w + b) % 15];
      r = {r[13:0], 1'(((st >> 3) ^ (st >> 2)) & 1)};
    end
    return r;
  endfunction

  // Results of the most recent run8 job (cycle 1 = first negedge after the
  // edge that sampled start).
  logic [7:0] got_w[$];
  int hs_cyc[$];
  int vrise[$];
  int done_cyc[$];

  task automatic run8(input logic [3:0] sd, input logic [7:0] n, input int pct, input int maxc);
    logic prev_v;
    int c;
    got_w.delete(); hs_cyc.delete(); vrise.delete(); done_cyc.delete();
    seed = sd; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_v = 1'b0;
    c = 1;
    while (c <= maxc) begin
      if (done8) done_cyc.push_back(c);
      if (valid8 && !prev_v) vrise.push_back(c);
      prev_v = valid8;
      word_ready = ($urandom_range(99) < pct);
      if (valid8 && word_ready) begin
        got_w.push_back(word8);
        hs_cyc.push_back(c);
      end
      if (done_cyc.size() > 0 && c >= done_cyc[0] + 2) break;
      @(negedge clk);
      c++;
    end
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] cs;
    repeat (2) @(negedge clk);
    checks++;
    if (word8 !== 8'h00 || valid8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || sf8 !== 1'b0)
      begin failures++; $display("FAIL reset_outputs: got word=%0h v=%0b b=%0b d=%0b sf=%0b expected all 0", word8, valid8, busy8, done8, sf8); end
    rst = 1'b1;
    @(negedge clk);
    seed = 4'd0; num_words = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1 || sf8 !== 1'b1)
      begin failures++; $display("FAIL pre_reset_busy: got b=%0b sf=%0b expected 1 1", busy8, sf8); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (word8 !== 8'h00 || valid8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || sf8 !== 1'b0)
      begin failures++; $display("FAIL reset_mid_shift: got word=%0h v=%0b b=%0b d=%0b sf=%0b expected all 0", word8, valid8, busy8, done8, sf8); end
    cs = dut8.u_core.r_s;
    checks++;
    if (cs !== 4'b0001)
      begin failures++; $display("FAIL reset_lfsr: got %0b expected 0001", cs); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] e0;
    e0 = 8'(model_word(4'd1, 8, 0));
    run8(4'd1, 8'd1, 100, 40);
    checks++;
    if (vrise.size() < 1 || vrise[0] != 10)
      begin failures++; $display("FAIL single_latency: got %0d expected 10", (vrise.size() > 0) ? vrise[0] : -1); end
    checks++;
    if (got_w.size() != 1 || got_w[0] !== e0)
      begin failures++; $display("FAIL single_word: got n=%0d w=%0h expected n=1 w=%0h", got_w.size(), (got_w.size() > 0) ? got_w[0] : 8'hxx, e0); end
    checks++;
    if (done_cyc.size() != 1 || hs_cyc.size() != 1 || done_cyc[0] != hs_cyc[0] + 1)
      begin failures++; $display("FAIL single_done: got %0d dones expected 1 right after handshake", done_cyc.size()); end
    checks++;
    if (busy8 !== 1'b0)
      begin failures++; $display("FAIL single_idle: got busy=%0b expected 0", busy8); end
  endtask

  task automatic test_two_words();
    logic [7:0] e0, e1;
    e0 = 8'(model_word(4'd1, 8, 0));
    e1 = 8'(model_word(4'd1, 8, 1));
    run8(4'd1, 8'd2, 100, 60);
    checks++;
    if (got_w.size() != 2 || got_w[0] !== e0 || got_w[1] !== e1)
      begin failures++; $display("FAIL two_words: got n=%0d expected %0h %0h", got_w.size(), e0, e1); end
    checks++;
    if (vrise.size() != 2 || vrise[1] - vrise[0] != 9)
      begin failures++; $display("FAIL two_words_spacing: got %0d rises expected 2 spaced 9", vrise.size()); end
    checks++;
    if (done_cyc.size() != 1 || hs_cyc.size() != 2 || done_cyc[0] != hs_cyc[1] + 1)
      begin failures++; $display("FAIL two_words_done: got %0d dones expected 1 after 2nd handshake", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e0, e1;
    int c;
    logic stable;
    e0 = 8'(model_word(4'd1, 8, 0));
    e1 = 8'(model_word(4'd1, 8, 1));
    seed = 4'd1; num_words = 8'd2; word_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!valid8 && c < 30) begin @(negedge clk); c++; end
    checks++;
    if (valid8 !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got 0 expected 1"); end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (valid8 !== 1'b1 || word8 !== e0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL bp_hold_stable: got word=%0h v=%0b expected %0h held", word8, valid8, e0); end
    word_ready = 1'b1;
    @(negedge clk);
    c = 0;
    while (!valid8 && c < 30) begin @(negedge clk); c++; end
    checks++;
    if (valid8 !== 1'b1 || word8 !== e1)
      begin failures++; $display("FAIL bp_second_word: got %0h v=%0b expected %0h", word8, valid8, e1); end
    @(negedge clk);
    word_ready = 1'b0;
    checks++;
    if (done8 !== 1'b1) begin failures++; $display("FAIL bp_done: got 0 expected 1"); end
    @(negedge clk);
  endtask

  task automatic test_zero_seed();
    logic [7:0] e0;
    e0 = 8'(model_word(4'd0, 8, 0));
    run8(4'd0, 8'd1, 100, 40);
    checks++;
    if (got_w.size() != 1 || got_w[0] !== e0 || sf8 !== 1'b1)
      begin failures++; $display("FAIL zero_seed: got n=%0d sf=%0b expected n=1 w=%0h sf=1", got_w.size(), sf8, e0); end
    run8(4'd3, 8'd0, 100, 10);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1)
      begin failures++; $display("FAIL zero_count_done: got %0d dones expected 1 at cycle 1", done_cyc.size()); end
    checks++;
    if (vrise.size() != 0 || sf8 !== 1'b0)
      begin failures++; $display("FAIL zero_count_valid: got %0d valids sf=%0b expected 0 0", vrise.size(), sf8); end
  endtask

  task automatic test_abort();
    int c;
    logic clean;
    seed = 4'd1; num_words = 8'd3; word_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!valid8 && c < 30) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || done8 !== 1'b0)
      begin failures++; $display("FAIL abort_idle: got b=%0b v=%0b d=%0b expected 0 0 0", busy8, valid8, done8); end
    clean = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done8 || valid8 || busy8) clean = 1'b0;
    end
    checks++;
    if (!clean) begin failures++; $display("FAIL abort_quiet: got activity expected none"); end
    // start and abort together in IDLE: the start is taken.
    seed = 4'd1; num_words = 8'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin failures++; $display("FAIL start_abort_idle: got busy=%0b expected 1", busy8); end
    c = 0;
    while (busy8 && c < 40) begin @(negedge clk); c++; end
    word_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_in_hold();
    int c;
    int nw;
    int nd;
    logic [7:0] w[$];
    seed = 4'd1; num_words = 8'd2; word_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!valid8 && c < 30) begin @(negedge clk); c++; end
    seed = 4'd5; num_words = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    word_ready = 1'b1;
    nw = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid8) begin w.push_back(word8); nw++; end
      if (done8) nd++;
      @(negedge clk);
    end
    word_ready = 1'b0;
    checks++;
    if (nw != 2 || nd != 1 || w[0] !== 8'(model_word(4'd1, 8, 0)) || w[1] !== 8'(model_word(4'd1, 8, 1)))
      begin failures++; $display("FAIL start_in_hold: got words=%0d dones=%0d expected 2 1 seed1 stream", nw, nd); end
    checks++;
    if (sf8 !== 1'b0 || busy8 !== 1'b0)
      begin failures++; $display("FAIL start_in_hold_state: got sf=%0b b=%0b expected 0 0", sf8, busy8); end
  endtask

  task automatic test_width15();
    logic [14:0] w[$];
    int first;
    int nd;
    logic [14:0] e0;
    e0 = model_word(4'd1, 15, 0);
    seed = 4'd1; num_words = 8'd2; word_ready = 1'b1; start15 = 1'b1;
    @(negedge clk);
    start15 = 1'b0;
    first = -1; nd = 0;
    for (int c = 1; c <= 60; c++) begin
      if (valid15) begin
        if (first < 0) first = c;
        w.push_back(word15);
      end
      if (done15) nd++;
      @(negedge clk);
    end
    word_ready = 1'b0;
    checks++;
    if (first != 17) begin failures++; $display("FAIL w15_latency: got %0d expected 17", first); end
    checks++;
    if (w.size() != 2 || nd != 1 || w[0] !== e0 || w[1] !== e0)
      begin failures++; $display("FAIL w15_period: got n=%0d dones=%0d expected 2 identical %0h", w.size(), nd, e0); end
  endtask

  task automatic test_random();
    logic [3:0] sd;
    int n;
    int pct;
    logic [7:0] e;
    for (int j = 0; j < 10; j++) begin
      sd = 4'($urandom_range(15));
      n = int'($urandom_range(1, 4));
      pct = int'($urandom_range(25, 100));
      run8(sd, 8'(n), pct, 600);
      checks++;
      if (got_w.size() != n)
        begin failures++; $display("FAIL rand_count job%0d: got %0d expected %0d", j, got_w.size(), n); end
      for (int k = 0; k < got_w.size() && k < n; k++) begin
        e = 8'(model_word(sd, 8, k));
        checks++;
        if (got_w[k] !== e)
          begin failures++; $display("FAIL rand_word job%0d w%0d: got %0h expected %0h", j, k, got_w[k], e); end
      end
      checks++;
      if (done_cyc.size() != 1 || hs_cyc.size() == 0 || done_cyc[0] != hs_cyc[hs_cyc.size()-1] + 1)
        begin failures++; $display("FAIL rand_done job%0d: got %0d dones expected 1 after last handshake", j, done_cyc.size()); end
      checks++;
      if (sf8 !== (sd == 4'd0))
        begin failures++; $display("FAIL rand_seed_fixed job%0d: got %0b expected %0b", j, sf8, (sd == 4'd0)); end
    end
  endtask

  initial begin
    int s;
    s = 1;
    for (int i = 0; i < 15; i++) begin
      ref_state[i] = s;
      s = ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
    end
    test_reset();
    test_single();
    test_two_words();
    test_backpressure();
    test_zero_seed();
    test_abort();
    test_start_in_hold();
    test_width15();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
